// File: rtl/xy_bram_sequencer_pkg.sv
// Shared types and width defaults for the XY BRAM pipeline.
// Loader, contour and VGA blocks import the same widths.
package xy_bram_sequencer_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_BIN_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD_RST    = 3'd1,
        S_LOAD        = 3'd2,
        S_GAP         = 3'd3,
        S_CONTOUR_RST = 3'd4,
        S_CONTOUR     = 3'd5,
        S_DISPLAY     = 3'd6,
        S_FAULT       = 3'd7
    } state_t;

endpackage

// File: rtl/xy_bram_sequencer_rise_detect.sv
// Registers a level input and flags its rising edge.
// The pulse is high for the single cycle where d rises.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/xy_bram_sequencer.sv
// Sequences loader -> contour -> display phases and
// arbitrates the shared BRAM port A between them.
module xy_bram_sequencer
    import xy_bram_sequencer_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BIN_W       = DEF_BIN_W,
    parameter int RST_CYCLES  = 4,
    parameter int WDOG_CYCLES = 1 << 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              restart,
    input  logic              load_done,
    input  logic              contour_done,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] contour_addr,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic [BIN_W-1:0]  load_din,
    input  logic [BIN_W-1:0]  contour_din,
    input  logic              load_we,
    input  logic              contour_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [BIN_W-1:0]  bram_din,
    output logic              bram_we,
    output logic              load_reset,
    output logic              contour_reset,
    output logic              contour_start,
    output logic [2:0]        phase,
    output logic              error
);

    localparam int CNT_W = $clog2(RST_CYCLES + 2) + 1;
    localparam int WD_W  = (WDOG_CYCLES > 2) ?
                           $clog2(WDOG_CYCLES) : 1;

    localparam logic [CNT_W-1:0] RST_LAST =
        CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  =
        WD_W'(WDOG_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd;
    logic [1:0]       rst_sync;
    logic             rst_n_s;
    logic             restart_rise;

    // Reset asserts immediately, releases two clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync[1];

    rise_detect u_restart (
        .clk   (clk),
        .rst_n (rst_n_s),
        .d     (restart),
        .rise  (restart_rise)
    );

    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state <= S_IDLE;
            cnt   <= '0;
            wd    <= '0;
            error <= 1'b0;
        end else if (restart_rise && state != S_IDLE) begin
            state <= S_LOAD_RST;
            cnt   <= '0;
            wd    <= '0;
            error <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state <= S_LOAD_RST;
                    cnt   <= '0;
                end
                S_LOAD_RST: begin
                    if (cnt == RST_LAST) begin
                        state <= S_LOAD;
                        wd    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        state <= S_GAP;
                        cnt   <= '0;
                    end else if (wd == WD_LAST) begin
                        state <= S_FAULT;
                        error <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= S_CONTOUR_RST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CONTOUR_RST: begin
                    if (cnt == RST_LAST) begin
                        state <= S_CONTOUR;
                        wd    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CONTOUR: begin
                    if (contour_done) begin
                        state <= S_DISPLAY;
                    end else if (wd == WD_LAST) begin
                        state <= S_FAULT;
                        error <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_DISPLAY: state <= S_DISPLAY;
                S_FAULT:   state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        bram_addr = '0;
        bram_din  = '0;
        bram_we   = 1'b0;
        case (state)
            S_LOAD: begin
                bram_addr = load_addr;
                bram_din  = load_din;
                bram_we   = load_we;
            end
            S_GAP: bram_addr = load_addr;
            S_CONTOUR: begin
                bram_addr = contour_addr;
                bram_din  = contour_din;
                bram_we   = contour_we;
            end
            S_DISPLAY: bram_addr = vga_addr;
            S_FAULT:   bram_addr = vga_addr;
            default: ;
        endcase
    end

    // A restart edge drops the enable before the state moves.
    assign contour_start = (state == S_CONTOUR) &&
                           !restart_rise;
    assign load_reset    = !rst_n_s ||
                           (state == S_LOAD_RST);
    assign contour_reset = !rst_n_s ||
                           (state == S_CONTOUR_RST);
    assign phase         = state;

endmodule

// File: tb/tb_xy_bram_sequencer.sv
// Bench for xy_bram_sequencer: port mux vectors, phase run,
// watchdog, restart priority and async reset.
module tb_xy_bram_sequencer;

    localparam int AW = 19;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          restart;
    logic          load_done;
    logic          contour_done;
    logic          load_we;
    logic          contour_we;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] contour_addr;
    logic [AW-1:0] vga_addr;
    logic [BW-1:0] load_din;
    logic [BW-1:0] contour_din;
    logic          w_zero = 1'b0;

    logic [AW-1:0] bram_addr;
    logic [BW-1:0] bram_din;
    logic          bram_we;
    logic          load_reset;
    logic          contour_reset;
    logic          contour_start;
    logic [2:0]    phase;
    logic          error;

    logic [AW-1:0] w_bram_addr;
    logic [BW-1:0] w_bram_din;
    logic          w_bram_we;
    logic          w_load_reset;
    logic          w_contour_reset;
    logic          w_contour_start;
    logic [2:0]    w_phase;
    logic          w_error;

    int n_chk  = 0;
    int n_fail = 0;
    int w_load_cyc = 0;

    typedef struct {
        logic [AW-1:0] la;
        logic [BW-1:0] ld;
        logic          lwe;
        logic [AW-1:0] ca;
        logic [BW-1:0] cd;
        logic          cwe;
        logic [AW-1:0] va;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_din;
        logic          e_we;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] din;
        logic          we;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    always #5 clk = ~clk;

    xy_bram_sequencer #(
        .ADDR_W(AW), .BIN_W(BW), .RST_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart),
        .load_done(load_done), .contour_done(contour_done),
        .load_addr(load_addr), .contour_addr(contour_addr),
        .vga_addr(vga_addr), .load_din(load_din),
        .contour_din(contour_din), .load_we(load_we),
        .contour_we(contour_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_we(bram_we),
        .load_reset(load_reset),
        .contour_reset(contour_reset),
        .contour_start(contour_start),
        .phase(phase), .error(error)
    );

    xy_bram_sequencer #(
        .ADDR_W(AW), .BIN_W(BW), .RST_CYCLES(4),
        .WDOG_CYCLES(64)
    ) dut_w (
        .clk(clk), .reset_n(reset_n), .restart(restart),
        .load_done(w_zero), .contour_done(w_zero),
        .load_addr(load_addr), .contour_addr(contour_addr),
        .vga_addr(vga_addr), .load_din(load_din),
        .contour_din(contour_din), .load_we(load_we),
        .contour_we(contour_we), .bram_addr(w_bram_addr),
        .bram_din(w_bram_din), .bram_we(w_bram_we),
        .load_reset(w_load_reset),
        .contour_reset(w_contour_reset),
        .contour_start(w_contour_start),
        .phase(w_phase), .error(w_error)
    );

    always @(negedge clk) begin
        if (w_phase == 3'd1) w_load_cyc = 0;
        else if (w_phase == 3'd2) w_load_cyc++;
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p,
                              input int lim,
                              input string nm);
        int k = 0;
        while (phase !== p && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(phase), 32'(p));
    endtask

    task automatic run_vecs(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1;
            load_addr    = vecs[i].la;
            load_din     = vecs[i].ld;
            load_we      = vecs[i].lwe;
            contour_addr = vecs[i].ca;
            contour_din  = vecs[i].cd;
            contour_we   = vecs[i].cwe;
            vga_addr     = vecs[i].va;
            sb.push_back('{vecs[i].e_addr, vecs[i].e_din,
                           vecs[i].e_we});
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("vec%0d_addr", i),
                32'(bram_addr), 32'(e.addr));
            chk($sformatf("vec%0d_din", i),
                32'(bram_din), 32'(e.din));
            chk($sformatf("vec%0d_we", i),
                32'(bram_we), 32'(e.we));
        end
    endtask

    initial begin
        int tr [$];
        int exp_tr [6];
        int lr_cnt, cr_cnt, gap_cnt, cs_bad, we_bad, n;

        vecs[0] = '{19'h00001, 3'd5, 1'b1, 19'h7FFFF, 3'd2,
                    1'b1, 19'h12C00, 19'h00001, 3'd5, 1'b1};
        vecs[1] = '{19'h4AFFF, 3'd7, 1'b0, 19'h00001, 3'd1,
                    1'b1, 19'h12C00, 19'h4AFFF, 3'd7, 1'b0};
        vecs[2] = '{19'h7FFFF, 3'd0, 1'b1, 19'h00002, 3'd3,
                    1'b0, 19'h00000, 19'h7FFFF, 3'd0, 1'b1};
        vecs[3] = '{19'h12345, 3'd3, 1'b0, 19'h54321, 3'd4,
                    1'b0, 19'h00ABC, 19'h12345, 3'd3, 1'b0};
        vecs[4] = '{19'h11111, 3'd7, 1'b1, 19'h22222, 3'd7,
                    1'b1, 19'h12C00, 19'h12C00, 3'd0, 1'b0};
        vecs[5] = '{19'h11111, 3'd1, 1'b1, 19'h22222, 3'd2,
                    1'b1, 19'h00000, 19'h00000, 3'd0, 1'b0};
        vecs[6] = '{19'h00000, 3'd5, 1'b1, 19'h00000, 3'd6,
                    1'b1, 19'h7FFFF, 19'h7FFFF, 3'd0, 1'b0};
        vecs[7] = '{19'h7FFFF, 3'd2, 1'b0, 19'h7FFFF, 3'd3,
                    1'b1, 19'h3ABCD, 19'h3ABCD, 3'd0, 1'b0};
        exp_tr = '{1, 2, 3, 4, 5, 6};

        reset_n      = 1'b0;
        restart      = 1'b0;
        load_done    = 1'b0;
        contour_done = 1'b0;
        load_we      = 1'b0;
        contour_we   = 1'b0;
        load_addr    = '0;
        contour_addr = '0;
        vga_addr     = '0;
        load_din     = '0;
        contour_din  = '0;

        #23;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cstart", 32'(contour_start), 32'd0);
        chk("rst_we", 32'(bram_we), 32'd0);
        chk("rst_lreset", 32'(load_reset), 32'd1);
        chk("rst_creset", 32'(contour_reset), 32'd1);

        @(negedge clk);
        reset_n = 1'b1;
        wait_phase(3'd2, 20, "reach_load");

        run_vecs(0, 3);

        n = 0;
        while (w_phase !== 3'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wdog_phase", 32'(w_phase), 32'd7);
        chk("wdog_load_cycles", 32'(w_load_cyc), 32'd64);
        chk("wdog_error", 32'(w_error), 32'd1);
        chk("no_wdog_main", 32'(phase), 32'd2);

        @(posedge clk);
        #1;
        restart    = 1'b1;
        load_we    = 1'b1;
        contour_we = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        chk("restart_w_phase", 32'(w_phase), 32'd1);
        chk("restart_w_error", 32'(w_error), 32'd0);

        lr_cnt  = 0;
        cr_cnt  = 0;
        gap_cnt = 0;
        cs_bad  = 0;
        we_bad  = 0;
        for (int c = 0; c < 400; c++) begin
            if (tr.size() == 0 || tr[$] != int'(phase))
                tr.push_back(int'(phase));
            if (load_reset) lr_cnt++;
            if (contour_reset) cr_cnt++;
            if (phase == 3'd3) gap_cnt++;
            if (contour_start !== (phase == 3'd5)) cs_bad++;
            if (bram_we !== (phase == 3'd2 || phase == 3'd5))
                we_bad++;
            if (phase == 3'd6) break;
            @(posedge clk);
            #1;
            if (c == 100) load_done = 1'b1;
            if (c == 300) contour_done = 1'b1;
            @(negedge clk);
        end
        chk("trace_len", 32'(tr.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < tr.size())
                chk($sformatf("trace%0d", i),
                    32'(tr[i]), 32'(exp_tr[i]));
        chk("load_reset_len", 32'(lr_cnt), 32'd4);
        chk("contour_reset_len", 32'(cr_cnt), 32'd4);
        chk("gap_len", 32'(gap_cnt), 32'd2);
        chk("cstart_only_contour", 32'(cs_bad), 32'd0);
        chk("we_by_phase", 32'(we_bad), 32'd0);

        run_vecs(4, 7);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        @(posedge clk);
        #1;
        restart      = 1'b1;
        contour_done = 1'b0;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        n = 0;
        while (phase === 3'd1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("held_done_rst_len", 32'(n), 32'd4);
        chk("held_done_load", 32'(phase), 32'd2);
        @(negedge clk);
        chk("held_done_gap", 32'(phase), 32'd3);

        wait_phase(3'd5, 20, "reach_contour");
        @(posedge clk);
        #1;
        contour_done = 1'b1;
        restart      = 1'b1;
        @(negedge clk);
        chk("cstart_drop", 32'(contour_start), 32'd0);
        @(posedge clk);
        #1;
        restart      = 1'b0;
        contour_done = 1'b0;
        @(negedge clk);
        chk("restart_wins", 32'(phase), 32'd1);

        contour_addr = 19'h5A5A5;
        contour_din  = 3'd6;
        wait_phase(3'd5, 20, "reach_contour2");
        chk("pre_rst_we", 32'(bram_we), 32'd1);
        chk("pre_rst_addr", 32'(bram_addr), 32'h5A5A5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_phase", 32'(phase), 32'd0);
        chk("async_cstart", 32'(contour_start), 32'd0);
        chk("async_we", 32'(bram_we), 32'd0);
        chk("async_addr", 32'(bram_addr), 32'd0);
        chk("async_din", 32'(bram_din), 32'd0);
        chk("async_lreset", 32'(load_reset), 32'd1);
        chk("async_creset", 32'(contour_reset), 32'd1);

        @(negedge clk);
        reset_n = 1'b1;
        wait_phase(3'd1, 10, "rerun_start");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
